aes_enc_hpc_stream_ctrl: RTL and testbench

Stream-control shell between the external valid/ready interfaces and one masked 32-bit HPC AES core plus its PRNG. It is the parametrised successor of the current top-level glue and adds five features:
- independent key reuse, so one key load serves many plaintexts;
- a bounded encryption count between reseeds, with forced reseed;
- an explicit seeding state machine;
- a registered ciphertext output stage;
- AES-128 or AES-256 key width.

It contains no datapath logic. It only routes and holds share buses (shared-bit encoding) and sequences handshakes.

---
 rtl/aes_enc_hpc_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_aes_enc_hpc_stream_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_hpc_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_hpc_stream_ctrl
// Description : Stream-control shell around a masked 32-bit HPC AES core and
//               its PRNG. Sequences seeding, key reuse, forced reseeding and a
//               one-entry registered ciphertext stage. No datapath logic; share
//               buses are only routed and held.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_hpc_stream_ctrl #(
  parameter int D            = 2,
  parameter int KEY_BITS     = 128,
  parameter int SEED_W       = 80,
  parameter int RESEED_LIMIT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // plaintext / key stream
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_key_update_i,
  input  logic [128*D-1:0]        in_shares_plaintext_i,
  input  logic [KEY_BITS*D-1:0]   in_shares_key_i,
  // seed stream
  input  logic                    in_seed_valid_i,
  output logic                    in_seed_ready_o,
  input  logic [SEED_W-1:0]       in_seed_i,
  // ciphertext stream
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [128*D-1:0]        out_shares_ciphertext_o,
  // AES core side
  output logic                    core_valid_in_o,
  input  logic                    core_in_ready_i,
  input  logic                    core_busy_i,
  output logic [128*D-1:0]        core_sh_plaintext_o,
  output logic [KEY_BITS*D-1:0]   core_sh_key_o,
  input  logic                    core_cipher_valid_i,
  output logic                    core_out_ready_o,
  input  logic [128*D-1:0]        core_sh_ciphertext_i,
  // PRNG side
  output logic                    prng_start_reseed_o,
  output logic [SEED_W-1:0]       prng_seed_o,
  input  logic                    prng_out_valid_i,
  input  logic                    prng_busy_i,
  // status
  output logic [CNT_W-1:0]        enc_count_o,
  output logic                    reseed_required_o
);

  // With forced reseed disabled the counter just saturates at full scale.
  localparam logic [CNT_W-1:0] c_LIMIT    = CNT_W'(RESEED_LIMIT);
  localparam logic             c_LIMIT_EN = (RESEED_LIMIT != 0);
  localparam logic [CNT_W-1:0] c_SAT      = c_LIMIT_EN ? c_LIMIT : {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_UNSEEDED  = 2'd0,
    ST_RESEEDING = 2'd1,
    ST_READY     = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    prev_busy_q;
  logic                    key_loaded_q;
  logic [KEY_BITS*D-1:0]   key_q;
  logic [CNT_W-1:0]        enc_count_q;
  logic [CNT_W-1:0]        enc_count_d;
  logic                    out_valid_q;
  logic [128*D-1:0]        out_data_q;

  logic                    w_busy_rise;
  logic                    w_busy_fall;
  logic                    w_reseed_req;
  logic                    w_gate;
  logic                    w_accept;
  logic                    w_capture;

  assign w_busy_rise  = ~prev_busy_q & prng_busy_i;
  assign w_busy_fall  = prev_busy_q & ~prng_busy_i;
  assign w_reseed_req = c_LIMIT_EN & (enc_count_q == c_LIMIT);

  // Shared qualifier of in_ready and core_valid_in: seeded, PRNG has fresh
  // randomness, no forced reseed pending and a key is available.
  assign w_gate = prng_out_valid_i & (state_q == ST_READY) & ~w_reseed_req &
                  (key_loaded_q | in_key_update_i);

  assign in_ready_o      = core_in_ready_i & w_gate;
  assign core_valid_in_o = in_valid_i & w_gate;
  assign w_accept        = in_valid_i & in_ready_o;

  // A waiting plaintext wins over a voluntary reseed; a forced one does not.
  assign prng_start_reseed_o = in_seed_valid_i & (state_q != ST_RESEEDING) & ~core_busy_i &
                               (w_reseed_req | (state_q == ST_UNSEEDED) | ~in_valid_i);
  assign prng_seed_o         = in_seed_i;
  assign in_seed_ready_o     = w_busy_rise;

  assign core_sh_plaintext_o = in_shares_plaintext_i;
  assign core_sh_key_o       = in_key_update_i ? in_shares_key_i : key_q;

  assign core_out_ready_o        = ~out_valid_q | out_ready_i;
  assign w_capture               = core_cipher_valid_i & core_out_ready_o;
  assign out_valid_o             = out_valid_q;
  assign out_shares_ciphertext_o = out_data_q;

  assign enc_count_o       = enc_count_q;
  assign reseed_required_o = w_reseed_req;

  // Encryption counter: cleared when the PRNG takes the seed, else saturating.
  always_comb begin
    enc_count_d = enc_count_q;
    if (w_busy_rise) begin
      enc_count_d = '0;
    end else if (w_accept && (enc_count_q != c_SAT)) begin
      enc_count_d = enc_count_q + 1'b1;
    end
  end

  // Seeding state machine and PRNG busy edge tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNSEEDED;
      prev_busy_q <= 1'b0;
    end else begin
      prev_busy_q <= prng_busy_i;
      case (state_q)
        ST_UNSEEDED:  if (prng_start_reseed_o) state_q <= ST_RESEEDING;
        ST_RESEEDING: if (w_busy_fall)         state_q <= ST_READY;
        ST_READY:     if (prng_start_reseed_o) state_q <= ST_RESEEDING;
        default:                               state_q <= ST_UNSEEDED;
      endcase
    end
  end

  // Key store and encryption counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_loaded_q <= 1'b0;
      key_q        <= '0;
      enc_count_q  <= '0;
    end else begin
      enc_count_q <= enc_count_d;
      if (w_accept && in_key_update_i) begin
        key_q        <= in_shares_key_i;
        key_loaded_q <= 1'b1;
      end
    end
  end

  // One-entry ciphertext register; data holds while the entry is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (w_capture) begin
      out_valid_q <= 1'b1;
      out_data_q  <= core_sh_ciphertext_i;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_hpc_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_enc_hpc_stream_ctrl
// Description : Directed self-checking bench for aes_enc_hpc_stream_ctrl with
//               a ciphertext scoreboard queue. Forced reseed after 4 encryptions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_enc_hpc_stream_ctrl;

  localparam int D        = 2;
  localparam int KEY_BITS = 128;
  localparam int SEED_W   = 80;
  localparam int LIMIT    = 4;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_key_update;
  logic [128*D-1:0] in_pt;
  logic [KEY_BITS*D-1:0] in_key;
  logic in_seed_valid, in_seed_ready;
  logic [SEED_W-1:0] in_seed;
  logic out_valid, out_ready;
  logic [128*D-1:0] out_ct;
  logic core_valid_in, core_in_ready, core_busy;
  logic [128*D-1:0] core_pt;
  logic [KEY_BITS*D-1:0] core_key;
  logic core_cipher_valid, core_out_ready;
  logic [128*D-1:0] core_ct;
  logic prng_start, prng_out_valid, prng_busy;
  logic [SEED_W-1:0] prng_seed;
  logic [CNT_W-1:0] enc_count;
  logic reseed_required;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses;
  logic [128*D-1:0] exp_q[$];
  logic [128*D-1:0] exp_ct;

  localparam logic [255:0] K1 = {8{32'hA5C3_0F1E}};
  localparam logic [255:0] KX = {8{32'h1234_5678}};
  localparam logic [255:0] P1 = {8{32'h0001_1001}};
  localparam logic [255:0] P2 = {8{32'h0002_2002}};
  localparam logic [255:0] P3 = {8{32'h0003_3003}};
  localparam logic [255:0] C1 = {8{32'hC1C1_0001}};
  localparam logic [255:0] C2 = {8{32'hC2C2_0002}};
  localparam logic [255:0] C3 = {8{32'hC3C3_0003}};
  localparam logic [79:0]  S1 = 80'hDEAD_BEEF_0123_4567_89AB;
  localparam logic [79:0]  S2 = 80'h0F0F_1E1E_2D2D_3C3C_4B4B;

  always #5 clk = ~clk;

  aes_enc_hpc_stream_ctrl #(
    .D(D), .KEY_BITS(KEY_BITS), .SEED_W(SEED_W), .RESEED_LIMIT(LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_key_update_i(in_key_update),
    .in_shares_plaintext_i(in_pt), .in_shares_key_i(in_key),
    .in_seed_valid_i(in_seed_valid), .in_seed_ready_o(in_seed_ready), .in_seed_i(in_seed),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_shares_ciphertext_o(out_ct),
    .core_valid_in_o(core_valid_in), .core_in_ready_i(core_in_ready), .core_busy_i(core_busy),
    .core_sh_plaintext_o(core_pt), .core_sh_key_o(core_key),
    .core_cipher_valid_i(core_cipher_valid), .core_out_ready_o(core_out_ready),
    .core_sh_ciphertext_i(core_ct),
    .prng_start_reseed_o(prng_start), .prng_seed_o(prng_seed),
    .prng_out_valid_i(prng_out_valid), .prng_busy_i(prng_busy),
    .enc_count_o(enc_count), .reseed_required_o(reseed_required)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  // Pop the scoreboard when the DUT hands over a ciphertext this cycle.
  task automatic out_hs(input string tag);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_unexpected"}, 1'b1, 1'b0);
      end else begin
        exp_ct = exp_q.pop_front();
        chk(tag, out_ct, exp_ct);
      end
    end else begin
      chk({tag, "_no_handshake"}, {out_valid, out_ready}, 2'b11);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_key_update = 0; in_pt = '0; in_key = '0;
    in_seed_valid = 0; in_seed = '0; out_ready = 0;
    core_in_ready = 0; core_busy = 0; core_cipher_valid = 0; core_ct = '0;
    prng_out_valid = 0; prng_busy = 0;
    tick(); tick();
    // reset values
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ct", out_ct, '0);
    chk("rst_enc_count", enc_count, '0);
    chk("rst_reseed_req", reseed_required, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_seed_ready", in_seed_ready, 1'b0);
    rst = 1'b0;
    tick();

    // initial seeding
    in_seed_valid = 1; in_seed = S1; settle();
    chk("seed_start", prng_start, 1'b1);
    chk("seed_value", prng_seed, S1);
    chk("seed_ready_idle", in_seed_ready, 1'b0);
    tick(); settle();
    chk("seed_start_reseeding", prng_start, 1'b0);
    prng_busy = 1; settle();
    pulses = int'(in_seed_ready);
    for (int i = 0; i < 9; i++) begin
      tick(); in_seed_valid = 0; settle();
      pulses += int'(in_seed_ready);
    end
    chk("seed_ready_pulses", pulses, 1);
    core_in_ready = 1; prng_out_valid = 1; in_key_update = 1; settle();
    chk("in_ready_reseeding", in_ready, 1'b0);
    prng_busy = 0;
    tick(); settle();
    chk("in_ready_ready", in_ready, 1'b1);
    prng_out_valid = 0; settle();
    chk("in_ready_no_prng", in_ready, 1'b0);
    prng_out_valid = 1; in_key_update = 0;

    // no key loaded: plaintext stalls
    in_valid = 1; in_pt = P1; in_key = K1;
    for (int i = 0; i < 50; i++) begin
      tick(); settle();
      chk("nokey_stall", {in_ready, core_valid_in}, 2'b00);
    end
    in_key_update = 1; settle();
    chk("key_upd_in_ready", in_ready, 1'b1);
    chk("key_upd_core_valid", core_valid_in, 1'b1);
    chk("key_upd_core_key", core_key, K1);
    chk("key_upd_core_pt", core_pt, P1);
    tick();
    in_key_update = 0; in_key = KX; in_pt = P2; settle();
    chk("enc1_count", enc_count, 1);
    chk("reuse2_core_key", core_key, K1);
    chk("reuse2_core_pt", core_pt, P2);
    tick();
    in_pt = P3; settle();
    chk("reuse3_core_key", core_key, K1);
    chk("reuse3_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 0; settle();
    chk("enc3_count", enc_count, 3);
    chk("enc3_no_reseed_req", reseed_required, 1'b0);

    // pending encryption beats a voluntary reseed, then forced reseed
    in_valid = 1; in_seed_valid = 1; in_seed = S2; settle();
    chk("pending_beats_reseed", prng_start, 1'b0);
    tick(); settle();
    chk("limit_count", enc_count, LIMIT);
    chk("limit_reseed_req", reseed_required, 1'b1);
    chk("limit_in_ready", {in_ready, core_valid_in}, 2'b00);
    core_busy = 1; settle();
    chk("forced_core_busy", prng_start, 1'b0);
    core_busy = 0; settle();
    chk("forced_start", prng_start, 1'b1);
    chk("forced_seed", prng_seed, S2);
    tick();
    in_valid = 0; prng_busy = 1; settle();
    chk("forced_seed_ready", in_seed_ready, 1'b1);
    tick();
    in_seed_valid = 0; settle();
    chk("reseed_count_clr", enc_count, 0);
    chk("reseed_req_clr", reseed_required, 1'b0);
    tick(); tick();
    prng_busy = 0;
    tick();

    // output stage back-pressure and drain
    out_ready = 0; core_cipher_valid = 1; core_ct = C1; exp_q.push_back(C1); settle();
    chk("out_core_ready_empty", core_out_ready, 1'b1);
    tick();
    core_ct = C2; exp_q.push_back(C2); settle();
    chk("out_valid_first", out_valid, 1'b1);
    chk("out_core_ready_full", core_out_ready, 1'b0);
    tick(); tick(); settle();
    chk("out_hold_valid", out_valid, 1'b1);
    chk("out_hold_data", out_ct, C1);
    out_ready = 1; settle();
    chk("out_core_ready_drain", core_out_ready, 1'b1);
    out_hs("out_first");
    tick();
    core_cipher_valid = 0; settle();
    out_hs("out_second");
    tick(); settle();
    chk("out_valid_empty", out_valid, 1'b0);
    chk("out_data_held", out_ct, C2);
    chk("out_queue_empty", exp_q.size(), 0);

    // reset during reseed
    in_seed_valid = 1; in_seed = S1; settle();
    chk("rst_rs_start", prng_start, 1'b1);
    tick();
    in_seed_valid = 0; prng_busy = 1;
    out_ready = 0; core_cipher_valid = 1; core_ct = C3; exp_q.push_back(C3);
    tick();
    core_cipher_valid = 0; prng_busy = 0; settle();
    chk("rst_rs_pre_valid", out_valid, 1'b1);
    #1 rst = 1'b1; #1;
    exp_q.delete();
    chk("rst_rs_out_valid", out_valid, 1'b0);
    chk("rst_rs_out_ct", out_ct, '0);
    chk("rst_rs_enc_count", enc_count, '0);
    tick();
    rst = 1'b0;
    in_seed_valid = 1; in_valid = 1; in_key_update = 1; in_key = K1; settle();
    chk("rst_rs_unseeded", prng_start, 1'b1);
    chk("rst_rs_in_ready", in_ready, 1'b0);

    // reseed again, encrypt once, reset mid-encryption
    tick();
    in_valid = 0; prng_busy = 1;
    tick();
    in_seed_valid = 0; prng_busy = 0;
    tick();
    in_valid = 1; settle();
    chk("rst_enc_in_ready", in_ready, 1'b1);
    tick(); settle();
    chk("rst_enc_count1", enc_count, 1);
    #1 rst = 1'b1; #1;
    chk("rst_enc_count0", enc_count, '0);
    chk("rst_enc_gated", {in_ready, core_valid_in}, 2'b00);
    in_valid = 0; in_key_update = 0;
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
